mips_pipe_core: RTL and testbench
=================================

MIPS_PIPE_CORE -- requirements
Module: mips_pipe_core

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide port: in_valid  input  1  inst holds a valid instruction this cycle.
REQ-004 SHALL provide port: inst  input  32  instruction word fetched from address inst_addr; ignored when in_valid=0.
REQ-005 SHALL provide port: out_valid  output  1  previous cycle's accepted instruction has retired.
REQ-006 SHALL provide port: inst_addr  output  32  byte address of the next instruction to fetch.
REQ-007 SHALL hold internal state arrays r[0:31] (32 bit, reset 0) and mem[0:4095] (32 bit, no reset), both probed hierarchically by the bench.

Function
REQ-008 SHALL, on every rising edge with in_valid=1, decode inst, execute it, and commit its register/memory write and the new inst_addr at that same edge.
REQ-009 SHALL assert out_valid exactly one cycle after each accepted instruction (out_valid = in_valid registered); with continuous in_valid, out_valid stays high with no gaps.
REQ-010 SHALL, with in_valid=0, hold r, mem and inst_addr unchanged and drive out_valid=0 the next cycle.
REQ-011 SHALL decode fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], func[5:0], imm[15:0].
REQ-012 SHALL execute R-type (opcode 0) writing r[rd]: func 0 and, 1 or, 2 add, 3 sub, 4 slt (signed compare, result 1/0), func>=5 sll (r[rs] << shamt).
REQ-013 SHALL execute I-type writing r[rt]: opcode 1 andi, 2 ori (imm zero-extended); 3 addi, 4 subi (imm sign-extended).
REQ-014 SHALL execute opcode 5 lw: r[rt] = mem[addr]; opcode 6 sw: mem[addr] = r[rt]; addr = (r[rs] + sext(imm)) modulo 4096, word-indexed.
REQ-015 SHALL execute opcode 7 beq / 8 bne comparing r[rs], r[rt]; taken: inst_addr += 4 + (sext(imm) << 2); not taken: inst_addr += 4.
REQ-016 SHALL advance inst_addr by 4 for all non-branch instructions; unknown opcodes 9..63 are NOPs (no write, +4).
REQ-017 SHALL treat r[0] as an ordinary writable register (not hardwired to zero).
REQ-018 SHALL perform all arithmetic modulo 2^32; inst_addr wraps at 2^32.
REQ-019 SHALL read source operands from r as committed before the current edge (each instruction observes all prior instructions' results; no stale-operand hazard).
REQ-020 SHALL, for lw/sw, read mem before the edge; sw followed by lw to the same address returns the stored value.
REQ-021 SHALL, when rd/rt equals rs or rt of the same instruction, compute with pre-edge values, then write.

Reset
REQ-022 SHALL, while rst=1, force out_valid=0, inst_addr=0, all r[i]=0, independent of clk.
REQ-023 SHALL leave mem contents unaffected by rst.
REQ-024 SHALL, on rst asserted mid-stream, discard any in-flight retirement (out_valid=0 next cycle) and restart fetch at address 0 after release.
REQ-025 SHALL accept the first instruction on the first rising edge after rst deasserts with in_valid=1.

Verification
REQ-026 SHALL pass: rst pulse, clk held -> out_valid=0, inst_addr=0, r[0..31]=0.
REQ-027 SHALL pass: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r1=5, r2=0xFFFFFFFD, r3=2, r4=1; out_valid high 4 consecutive cycles starting one cycle after first in_valid; inst_addr 0,4,8,12,16.
REQ-028 SHALL pass: ori r5,r0,0x8000; andi r6,r5,0xFFFF; sll r7,r5,shamt=4 -> r5=0x00008000, r6=0x00008000, r7=0x00080000.
REQ-029 SHALL pass: addi r1,r0,10; sw r1,3(r0); lw r2,3(r0); lw r3,-1(r1) with mem[9]=0x1234 -> mem[3]=10, r2=10, r3=0x1234.
REQ-030 SHALL pass: at 0x0 addi r1,r0,1; at 0x4 bne r1,r0,+2 -> inst_addr 0x10; beq r1,r0,-1 at 0x10 (not taken) -> inst_addr 0x14.
REQ-031 SHALL pass: in_valid dropped one cycle mid-stream, then rst pulsed mid-stream -> out_valid 0 for exactly the idle cycle; after rst, inst_addr=0, r cleared, mem retained.

Source files
------------

// File: rtl/mips_pipe_core.sv
// Single-cycle MIPS-like core: decodes, executes and commits one instruction per
// accepted edge; out_valid reports retirement one cycle later.
module mips_pipe_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] inst,
   output logic        out_valid,
   output logic [31:0] inst_addr
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'd0,
      OP_ANDI  = 6'd1,
      OP_ORI   = 6'd2,
      OP_ADDI  = 6'd3,
      OP_SUBI  = 6'd4,
      OP_LW    = 6'd5,
      OP_SW    = 6'd6,
      OP_BEQ   = 6'd7,
      OP_BNE   = 6'd8
   } opcode_e;

   logic [31:0] r   [0:31];
   logic [31:0] mem [0:4095];

   logic [31:0] inst_addr_q, inst_addr_d;
   logic        out_valid_q;

   opcode_e     opcode;
   logic [4:0]  rs_idx, rt_idx, rd_idx, shamt;
   logic [5:0]  func;
   logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
   logic [11:0] mem_idx;

   logic        reg_we;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        mem_we;

   assign opcode   = opcode_e'(inst[31:26]);
   assign rs_idx   = inst[25:21];
   assign rt_idx   = inst[20:16];
   assign rd_idx   = inst[15:11];
   assign shamt    = inst[10:6];
   assign func     = inst[5:0];
   assign imm_sext = {{16{inst[15]}}, inst[15:0]};
   assign imm_zext = {16'd0, inst[15:0]};

   // Operands come straight from the committed register file, so every
   // instruction sees all earlier results without forwarding.
   assign rs_val  = r[rs_idx];
   assign rt_val  = r[rt_idx];
   assign mem_idx = 12'(rs_val + imm_sext);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      reg_we      = 1'b0;
      reg_waddr   = rt_idx;
      reg_wdata   = '0;
      mem_we      = 1'b0;
      inst_addr_d = inst_addr_q + 32'd4;
      case (opcode)
         OP_RTYPE: begin
            reg_we    = 1'b1;
            reg_waddr = rd_idx;
            case (func)
               6'd0:    reg_wdata = rs_val & rt_val;
               6'd1:    reg_wdata = rs_val | rt_val;
               6'd2:    reg_wdata = rs_val + rt_val;
               6'd3:    reg_wdata = rs_val - rt_val;
               6'd4:    reg_wdata = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
               default: reg_wdata = rs_val << shamt;
            endcase
         end
         OP_ANDI: begin
            reg_we    = 1'b1;
            reg_wdata = rs_val & imm_zext;
         end
         OP_ORI: begin
            reg_we    = 1'b1;
            reg_wdata = rs_val | imm_zext;
         end
         OP_ADDI: begin
            reg_we    = 1'b1;
            reg_wdata = rs_val + imm_sext;
         end
         OP_SUBI: begin
            reg_we    = 1'b1;
            reg_wdata = rs_val - imm_sext;
         end
         OP_LW: begin
            reg_we    = 1'b1;
            reg_wdata = mem[mem_idx];
         end
         OP_SW: mem_we = 1'b1;
         OP_BEQ: begin
            if (rs_val == rt_val)
               inst_addr_d = inst_addr_q + 32'd4 + {imm_sext[29:0], 2'b00};
         end
         OP_BNE: begin
            if (rs_val != rt_val)
               inst_addr_d = inst_addr_q + 32'd4 + {imm_sext[29:0], 2'b00};
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_addr_q <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < 32; i++) r[i] <= '0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            inst_addr_q <= inst_addr_d;
            if (reg_we) r[reg_waddr] <= reg_wdata;
         end
      end
   end

   // NOTE: the data memory has no reset; its contents must survive rst.
   always_ff @(posedge clk) begin
      if (in_valid && mem_we && !rst) mem[mem_idx] <= rt_val;
   end

   assign inst_addr = inst_addr_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mips_pipe_core.sv
// Directed bench for mips_pipe_core: vector tables for straight-line code plus
// hand-written idle, reset, memory and branch sequences.
module tb_mips_pipe_core;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] inst;
   logic        out_valid;
   logic [31:0] inst_addr;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] exp_addr;
      int          reg_idx;
      logic [31:0] reg_val;
   } vec_t;

   mips_pipe_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inst      (inst),
      .out_valid (out_valid),
      .inst_addr (inst_addr)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clk);
      in_valid = 1'b1;
      inst     = v.inst;
      @(posedge clk);
      #1;
      check({tag, " addr"}, inst_addr, v.exp_addr);
      check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " reg"}, dut.r[v.reg_idx], v.reg_val);
   endtask

   task automatic idle_check(input string tag, input logic [31:0] exp_addr);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " addr"}, inst_addr, exp_addr);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check({tag, " valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " addr"}, inst_addr, 32'd0);
      for (int i = 0; i < 32; i++) check($sformatf("%s r%0d", tag, i), dut.r[i], 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check({tag, " post valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " post addr"}, inst_addr, 32'd0);
   endtask

   vec_t tab_a [17];
   vec_t tab_m [5];
   vec_t tab_b [7];

   initial begin
      // Arithmetic, logic, shift, NOP, store and same-register cases.
      tab_a[0]  = '{enc_i(6'd3, 5'd0, 5'd1, 16'd5),           32'd4,  1,  32'd5};
      tab_a[1]  = '{enc_i(6'd3, 5'd0, 5'd2, 16'hFFFD),        32'd8,  2,  32'hFFFF_FFFD};
      tab_a[2]  = '{enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd2),      32'd12, 3,  32'd2};
      tab_a[3]  = '{enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'd4),      32'd16, 4,  32'd1};
      tab_a[4]  = '{enc_i(6'd2, 5'd0, 5'd5, 16'h8000),        32'd20, 5,  32'h0000_8000};
      tab_a[5]  = '{enc_i(6'd1, 5'd5, 5'd6, 16'hFFFF),        32'd24, 6,  32'h0000_8000};
      tab_a[6]  = '{enc_r(5'd5, 5'd0, 5'd7, 5'd4, 6'd5),      32'd28, 7,  32'h0008_0000};
      tab_a[7]  = '{enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'd3),      32'd32, 8,  32'd8};
      tab_a[8]  = '{enc_r(5'd2, 5'd1, 5'd10, 5'd0, 6'd0),     32'd36, 10, 32'd5};
      tab_a[9]  = '{enc_r(5'd5, 5'd1, 5'd11, 5'd0, 6'd1),     32'd40, 11, 32'h0000_8005};
      tab_a[10] = '{enc_i(6'd4, 5'd1, 5'd12, 16'd7),          32'd44, 12, 32'hFFFF_FFFE};
      tab_a[11] = '{enc_r(5'd1, 5'd2, 5'd13, 5'd0, 6'd4),     32'd48, 13, 32'd0};
      tab_a[12] = '{enc_i(6'd3, 5'd2, 5'd15, 16'd3),          32'd52, 15, 32'd0};
      tab_a[13] = '{enc_i(6'd9, 5'd0, 5'd1, 16'd77),          32'd56, 1,  32'd5};
      tab_a[14] = '{enc_i(6'd2, 5'd0, 5'd9, 16'h1234),        32'd60, 9,  32'h0000_1234};
      tab_a[15] = '{enc_i(6'd6, 5'd0, 5'd9, 16'd9),           32'd64, 9,  32'h0000_1234};
      tab_a[16] = '{enc_r(5'd2, 5'd2, 5'd2, 5'd0, 6'd2),      32'd68, 2,  32'hFFFF_FFFA};

      // Memory traffic after a reset; mem[9] was stored before it.
      tab_m[0] = '{enc_i(6'd3, 5'd0, 5'd1, 16'd10),           32'd4,  1, 32'd10};
      tab_m[1] = '{enc_i(6'd6, 5'd0, 5'd1, 16'd3),            32'd8,  1, 32'd10};
      tab_m[2] = '{enc_i(6'd5, 5'd0, 5'd2, 16'd3),            32'd12, 2, 32'd10};
      tab_m[3] = '{enc_i(6'd5, 5'd1, 5'd3, 16'hFFFF),         32'd16, 3, 32'h0000_1234};
      tab_m[4] = '{enc_i(6'd5, 5'd1, 5'd4, 16'd4095),         32'd20, 4, 32'h0000_1234};

      // Branches, writable r0 and program-counter wrap.
      tab_b[0] = '{enc_i(6'd3, 5'd0, 5'd1, 16'd1),            32'h0000_0004, 1, 32'd1};
      tab_b[1] = '{enc_i(6'd8, 5'd1, 5'd0, 16'd2),            32'h0000_0010, 1, 32'd1};
      tab_b[2] = '{enc_i(6'd7, 5'd1, 5'd0, 16'hFFFF),         32'h0000_0014, 1, 32'd1};
      tab_b[3] = '{enc_i(6'd7, 5'd1, 5'd1, 16'hFFFF),         32'h0000_0014, 1, 32'd1};
      tab_b[4] = '{enc_i(6'd8, 5'd1, 5'd1, 16'd5),            32'h0000_0018, 1, 32'd1};
      tab_b[5] = '{enc_i(6'd3, 5'd0, 5'd0, 16'd7),            32'h0000_001C, 0, 32'd7};
      tab_b[6] = '{enc_i(6'd7, 5'd0, 5'd0, 16'h8000),         32'hFFFE_0020, 0, 32'd7};

      in_valid = 1'b0;
      inst     = '0;
      rst      = 1'b0;

      // Reset with the clock stopped.
      #1 rst = 1'b1;
      #1;
      check("rst valid", {31'd0, out_valid}, 32'd0);
      check("rst addr", inst_addr, 32'd0);
      for (int i = 0; i < 32; i++) check($sformatf("rst r%0d", i), dut.r[i], 32'd0);
      #1 rst = 1'b0;
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      check("idle after rst valid", {31'd0, out_valid}, 32'd0);

      for (int i = 0; i < 17; i++) apply(tab_a[i], $sformatf("A%0d", i));
      check("A mem9", dut.mem[9], 32'h0000_1234);

      idle_check("gap", 32'd68);
      check("gap r2 held", dut.r[2], 32'hFFFF_FFFA);
      apply('{enc_i(6'd3, 5'd0, 5'd20, 16'd1), 32'd72, 20, 32'd1}, "resume");

      @(negedge clk);
      in_valid = 1'b1;
      inst     = enc_i(6'd3, 5'd0, 5'd21, 16'd9);
      pulse_reset("midrst");
      check("midrst mem9 kept", dut.mem[9], 32'h0000_1234);

      for (int i = 0; i < 5; i++) apply(tab_m[i], $sformatf("M%0d", i));
      check("M mem3", dut.mem[3], 32'd10);

      pulse_reset("rst2");
      for (int i = 0; i < 7; i++) apply(tab_b[i], $sformatf("B%0d", i));

      idle_check("tail", 32'hFFFE_0020);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
